id_exe_stage: RTL
=================

# id_exe_stage

Pipeline register between instruction decode and execute. Captures the decoder's control word (immediate select, write-back enable, memory read/write enables, ALU command, branch type) together with the operand values, destination register and PC. Supports freeze, flush-to-bubble and load-use hazard bubble insertion. Feeds the EXE stage ALU and branch-resolution logic.

## Interface
- REG_ADDR_W, 5, register index width
- DATA_W, 32, operand and PC width

- clk  in  1  rising-edge clock
- rst  in  1  asynchronous reset, active-high
- Freeze  in  1  hold all stage contents
- Flush  in  1  branch taken in EXE; next load is a bubble
- ID_Valid  in  1  decode stage holds a real instruction
- Is_Imm_In, WB_En_In, MEM_R_En_In, MEM_W_En_In  in  1 each  decoder control bits
- EXE_Cmd_In  in  4  ALU command
- BR_Type_In  in  2  00 none, 01 BEZ, 10 BNE, 11 JMP
- PC_In, Val1_In, Val2_In, Reg2_In  in  DATA_W each  PC+1, operand 1, operand 2 (register or sign-extended immediate), store data
- Dest_In, Src1_In, Src2_In  in  REG_ADDR_W each  register indices
- Src2_Used_In  in  1  Src2 is actually read (R-type, ST, BNE)
- *_Out for every *_In above except Src1/Src2/Src2_Used  out  same width  registered copies
- Valid_Out  out  1  EXE holds a real instruction
- Hazard_Stall  out  1  load-use stall request to PC and IF/ID

## Operation
- Per-edge action priority: rst > Flush > Freeze > Hazard_Stall > load.
  - rst: clear everything.
  - Flush: load bubble.
  - Freeze: hold.
  - Hazard_Stall: load bubble.
  - ID_Valid=0: load bubble.
  - Otherwise: capture all inputs, Valid_Out=1.
- Bubble:
  - Valid_Out=0; WB_En, MEM_R_En, MEM_W_En, Is_Imm all 0; BR_Type 00; EXE_Cmd 0000.
  - Data fields (PC, Val1, Val2, Reg2, Dest) take 0.
- EXE_Cmd_In may be X for NOP/branches. It is captured as-is on a valid load; the bench must not check it when WB_En_In=0 and MEM_*=0.
- Load-use detection, combinational:
  - Hazard_Stall = Valid_Out & MEM_R_En_Out & (Dest_Out != 0) & ID_Valid & ((Src1_In == Dest_Out) | (Src2_Used_In & Src2_In == Dest_Out)).
  - Hazard_Stall is forced to 0 while Flush=1. The flushed decode instruction is discarded upstream.
- Register 0 never raises a hazard.
- Freeze and Hazard_Stall together: Freeze wins. Hazard_Stall stays asserted and bubble insertion occurs on the first unfrozen edge.

## Timing
- Latency: exactly 1 cycle from *_In to *_Out.
- Reset value of every output: 0, including Valid_Out and Hazard_Stall.
- Reset asynchronously clears registers mid-operation. Outputs read 0 in the same cycle rst rises and stay 0 until the first edge after rst falls.
- Hazard_Stall is asserted the same cycle the dependent instruction sits in ID.
  - One bubble is inserted.
  - On the next cycle the load has left EXE, so Hazard_Stall drops and the dependent instruction is captured.
  - Stall length is exactly 1 cycle.
- Back-to-back loads into the same Dest, with a dependent instruction following: one stall, relative to the second load only.
- Flush asserted for one cycle produces exactly one bubble. Flush held N cycles produces N bubbles.

## Configuration
- HAZARD_DETECT_EN defined: load-use logic as above.
- HAZARD_DETECT_EN undefined:
  - Hazard_Stall is tied to 0.
  - The detection comparators are not synthesised.
  - The software schedule guarantees no load-use adjacency.
- All other behaviour is identical in both builds.

## Structure
- Shared package pipe_pkg:
  - BR_Type encodings BR_NONE, BR_BEZ, BR_BNE, BR_JMP.
  - EXE_Cmd encodings: ADD 0000, SUB 0010, AND 0100, OR 0101, NOR 0110, XOR 0111, SHL 1000, SRA 1001, SRL 1010.
  - REG_ADDR_W, DATA_W defaults.
  - Bubble control-word constant.
- One sub-module, hazard_detect: purely combinational load-use comparator, instantiated only under HAZARD_DETECT_EN.
- The pipeline registers stay in id_exe_stage.

## Test plan
- Reset mid-stream:
  - Stimulus: load ADD (WB_En=1, EXE_Cmd=0000, Dest=3), then assert rst between edges.
  - Required: all outputs 0 immediately; first load after release has 1-cycle latency.
- Plain load:
  - Stimulus: ST with Val1=0x10, Reg2=0xAB, Is_Imm=1.
  - Required: next cycle MEM_W_En_Out=1, WB_En_Out=0, Val1_Out=0x10, Reg2_Out=0xAB, Valid_Out=1.
- Load-use:
  - Stimulus: LD Dest=5 in EXE, ADD Src1=5 in ID.
  - Required: Hazard_Stall=1 that cycle; next cycle Valid_Out=0 and Hazard_Stall=0; the following edge captures the ADD.
  - Repeat with Dest=0: no stall.
- Src2 gating:
  - Stimulus: LD Dest=7 in EXE; ADDI with Src2_In=7, Src2_Used_In=0.
  - Required: no stall. With Src2_Used_In=1 (BNE): stall.
- Priority:
  - Flush=1 with Freeze=1 and a pending hazard: bubble loaded, Hazard_Stall=0.
  - Freeze=1 alone for 3 cycles: outputs unchanged.
- Build without HAZARD_DETECT_EN: the load-use scenario gives Hazard_Stall=0 and the ADD is captured immediately after the LD.

Source files
------------

// File: rtl/pipe_pkg.sv
// Shared ID/EXE pipeline definitions: branch and ALU encodings,
// default widths and the bubble control word.
package pipe_pkg;

    localparam int REG_ADDR_W_DEF = 5;
    localparam int DATA_W_DEF     = 32;

    typedef enum logic [1:0] {
        BR_NONE = 2'b00,
        BR_BEZ  = 2'b01,
        BR_BNE  = 2'b10,
        BR_JMP  = 2'b11
    } br_type_e;

    typedef enum logic [3:0] {
        EXE_ADD = 4'b0000,
        EXE_SUB = 4'b0010,
        EXE_AND = 4'b0100,
        EXE_OR  = 4'b0101,
        EXE_NOR = 4'b0110,
        EXE_XOR = 4'b0111,
        EXE_SHL = 4'b1000,
        EXE_SRA = 4'b1001,
        EXE_SRL = 4'b1010
    } exe_cmd_e;

    // exe_cmd/br_type kept as raw bits so don't-care decodes pass through
    typedef struct packed {
        logic       is_imm;
        logic       wb_en;
        logic       mem_r_en;
        logic       mem_w_en;
        logic [3:0] exe_cmd;
        logic [1:0] br_type;
    } ctrl_t;

    localparam ctrl_t CTRL_BUBBLE = '{
        is_imm:   1'b0,
        wb_en:    1'b0,
        mem_r_en: 1'b0,
        mem_w_en: 1'b0,
        exe_cmd:  4'b0000,
        br_type:  2'b00
    };

endpackage

// File: rtl/id_exe_stage_if.sv
// ID/EXE bundle: decoder-side inputs, stage control, registered
// outputs. master = decode/hazard side, slave = the stage register.
interface id_exe_if #(
    parameter int REG_ADDR_W = pipe_pkg::REG_ADDR_W_DEF,
    parameter int DATA_W     = pipe_pkg::DATA_W_DEF
);
    logic                  Freeze;
    logic                  Flush;
    logic                  ID_Valid;
    logic                  Is_Imm_In;
    logic                  WB_En_In;
    logic                  MEM_R_En_In;
    logic                  MEM_W_En_In;
    logic [3:0]            EXE_Cmd_In;
    logic [1:0]            BR_Type_In;
    logic [DATA_W-1:0]     PC_In;
    logic [DATA_W-1:0]     Val1_In;
    logic [DATA_W-1:0]     Val2_In;
    logic [DATA_W-1:0]     Reg2_In;
    logic [REG_ADDR_W-1:0] Dest_In;
    logic [REG_ADDR_W-1:0] Src1_In;
    logic [REG_ADDR_W-1:0] Src2_In;
    logic                  Src2_Used_In;

    logic                  Is_Imm_Out;
    logic                  WB_En_Out;
    logic                  MEM_R_En_Out;
    logic                  MEM_W_En_Out;
    logic [3:0]            EXE_Cmd_Out;
    logic [1:0]            BR_Type_Out;
    logic [DATA_W-1:0]     PC_Out;
    logic [DATA_W-1:0]     Val1_Out;
    logic [DATA_W-1:0]     Val2_Out;
    logic [DATA_W-1:0]     Reg2_Out;
    logic [REG_ADDR_W-1:0] Dest_Out;
    logic                  Valid_Out;
    logic                  Hazard_Stall;

    modport master (
        output Freeze, Flush, ID_Valid,
        output Is_Imm_In, WB_En_In, MEM_R_En_In, MEM_W_En_In,
        output EXE_Cmd_In, BR_Type_In,
        output PC_In, Val1_In, Val2_In, Reg2_In,
        output Dest_In, Src1_In, Src2_In, Src2_Used_In,
        input  Is_Imm_Out, WB_En_Out, MEM_R_En_Out, MEM_W_En_Out,
        input  EXE_Cmd_Out, BR_Type_Out,
        input  PC_Out, Val1_Out, Val2_Out, Reg2_Out,
        input  Dest_Out, Valid_Out, Hazard_Stall
    );

    modport slave (
        input  Freeze, Flush, ID_Valid,
        input  Is_Imm_In, WB_En_In, MEM_R_En_In, MEM_W_En_In,
        input  EXE_Cmd_In, BR_Type_In,
        input  PC_In, Val1_In, Val2_In, Reg2_In,
        input  Dest_In, Src1_In, Src2_In, Src2_Used_In,
        output Is_Imm_Out, WB_En_Out, MEM_R_En_Out, MEM_W_En_Out,
        output EXE_Cmd_Out, BR_Type_Out,
        output PC_Out, Val1_Out, Val2_Out, Reg2_Out,
        output Dest_Out, Valid_Out, Hazard_Stall
    );

endinterface

// File: rtl/id_exe_stage_hazard_detect.sv
// hazard_detect: combinational load-use comparator between the load
// in EXE and the instruction in ID. r0 never matches.
// In: EXE valid/mem_r/dest, ID valid/src1/src2/src2_used. Out: stall.
module hazard_detect #(
    parameter int REG_ADDR_W = pipe_pkg::REG_ADDR_W_DEF
) (
    input  logic                  ex_valid,
    input  logic                  ex_mem_r_en,
    input  logic [REG_ADDR_W-1:0] ex_dest,
    input  logic                  id_valid,
    input  logic [REG_ADDR_W-1:0] id_src1,
    input  logic [REG_ADDR_W-1:0] id_src2,
    input  logic                  id_src2_used,
    output logic                  stall
);

    logic ex_load;
    logic src_hit;

    assign ex_load = ex_valid & ex_mem_r_en & (ex_dest != '0);
    assign src_hit = (id_src1 == ex_dest)
                   | (id_src2_used & (id_src2 == ex_dest));
    assign stall   = ex_load & id_valid & src_hit;

endmodule

// File: rtl/id_exe_stage.sv
// ID/EXE pipeline register with freeze, flush bubble and load-use
// bubble insertion. Ports: clk, rst (async, active-high), bus (slave).
// HAZARD_DETECT_EN enables load-use detection; else Hazard_Stall = 0.
module id_exe_stage
    import pipe_pkg::*;
#(
    parameter int REG_ADDR_W = REG_ADDR_W_DEF,
    parameter int DATA_W     = DATA_W_DEF
) (
    input  logic    clk,
    input  logic    rst,
    id_exe_if.slave bus
);

    ctrl_t                 ctrl_q;
    ctrl_t                 ctrl_in;
    logic                  valid_q;
    logic [DATA_W-1:0]     pc_q;
    logic [DATA_W-1:0]     val1_q;
    logic [DATA_W-1:0]     val2_q;
    logic [DATA_W-1:0]     reg2_q;
    logic [REG_ADDR_W-1:0] dest_q;
    logic                  hazard;

`ifdef HAZARD_DETECT_EN
    logic hazard_raw;

    hazard_detect #(
        .REG_ADDR_W (REG_ADDR_W)
    ) u_hazard_detect (
        .ex_valid     (valid_q),
        .ex_mem_r_en  (ctrl_q.mem_r_en),
        .ex_dest      (dest_q),
        .id_valid     (bus.ID_Valid),
        .id_src1      (bus.Src1_In),
        .id_src2      (bus.Src2_In),
        .id_src2_used (bus.Src2_Used_In),
        .stall        (hazard_raw)
    );

    // A flushed ID instruction is discarded upstream, never stalled
    assign hazard = hazard_raw & ~bus.Flush;
`else
    logic hz_unused;

    assign hz_unused = ^{bus.Src1_In, bus.Src2_In, bus.Src2_Used_In};
    assign hazard    = 1'b0;
`endif

    assign ctrl_in = '{
        is_imm:   bus.Is_Imm_In,
        wb_en:    bus.WB_En_In,
        mem_r_en: bus.MEM_R_En_In,
        mem_w_en: bus.MEM_W_En_In,
        exe_cmd:  bus.EXE_Cmd_In,
        br_type:  bus.BR_Type_In
    };

    // Flush beats Freeze; a frozen hazard turns into a bubble on the
    // first unfrozen edge because Hazard_Stall is still asserted then.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ctrl_q  <= CTRL_BUBBLE;
            valid_q <= 1'b0;
            pc_q    <= '0;
            val1_q  <= '0;
            val2_q  <= '0;
            reg2_q  <= '0;
            dest_q  <= '0;
        end else if (bus.Flush
                     || (!bus.Freeze && (hazard || !bus.ID_Valid))) begin
            ctrl_q  <= CTRL_BUBBLE;
            valid_q <= 1'b0;
            pc_q    <= '0;
            val1_q  <= '0;
            val2_q  <= '0;
            reg2_q  <= '0;
            dest_q  <= '0;
        end else if (!bus.Freeze) begin
            ctrl_q  <= ctrl_in;
            valid_q <= 1'b1;
            pc_q    <= bus.PC_In;
            val1_q  <= bus.Val1_In;
            val2_q  <= bus.Val2_In;
            reg2_q  <= bus.Reg2_In;
            dest_q  <= bus.Dest_In;
        end
    end

    assign bus.Is_Imm_Out   = ctrl_q.is_imm;
    assign bus.WB_En_Out    = ctrl_q.wb_en;
    assign bus.MEM_R_En_Out = ctrl_q.mem_r_en;
    assign bus.MEM_W_En_Out = ctrl_q.mem_w_en;
    assign bus.EXE_Cmd_Out  = ctrl_q.exe_cmd;
    assign bus.BR_Type_Out  = ctrl_q.br_type;
    assign bus.PC_Out       = pc_q;
    assign bus.Val1_Out     = val1_q;
    assign bus.Val2_Out     = val2_q;
    assign bus.Reg2_Out     = reg2_q;
    assign bus.Dest_Out     = dest_q;
    assign bus.Valid_Out    = valid_q;
    assign bus.Hazard_Stall = hazard;

endmodule
